pc_sequencer: RTL

Parametrised program-counter sequencer for the 5-bit-opcode core. It consumes the 3-bit jump-type code from the decoder together with the ALU flags, and holds the PC, the zero/carry flag register and a return-address stack of configurable depth for `jsb`/`ret`. It sits between the decoder/ALU and instruction memory. A fault state traps stack overflow and underflow.

---
 rtl/pc_seq_pkg.sv | 12 +
 rtl/return_stack.sv | 35 +++
 rtl/pc_sequencer.sv | 87 ++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: jump-type encoding shared with the decoder and the sequencer FSM states
package pc_seq_pkg;
    localparam logic [2:0] JT_NONE = 3'b000;
    localparam logic [2:0] JT_JZ   = 3'b001;
    localparam logic [2:0] JT_JNZ  = 3'b010;
    localparam logic [2:0] JT_JC   = 3'b011;
    localparam logic [2:0] JT_JNC  = 3'b100;
    localparam logic [2:0] JT_JMP  = 3'b101;
    localparam logic [2:0] JT_JSB  = 3'b110;
    localparam logic [2:0] JT_RET  = 3'b111;
    typedef enum logic {RUN, FAULT} state_t;
endpackage

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses, synchronous write, combinational top-of-stack read
module return_stack #(
    parameter int W     = 12,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [LW-1:0] tix;
    // entry storage has no reset; only the level is architecturally visible after reset
    always_ff @(posedge clk)
        if (push && !full) mem[level[AW-1:0]] <= din;
    // occupancy counter
    always_ff @(posedge clk or posedge rst)
        if (rst) level <= '0;
        else if (push && !full) level <= level + 1'b1;
        else if (pop && !empty) level <= level - 1'b1;
    // top is the last written entry; index pinned to 0 when empty to stay in range
    always_comb begin
        full  = level == LW'(DEPTH);
        empty = level == '0;
        tix   = empty ? '0 : level - 1'b1;
        top   = mem[tix[AW-1:0]];
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, flag register, branch resolution and call/return with stack fault trap
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          PC_W        = 12,
    parameter int          STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int          LW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2:0]      jump_type,
    input  logic [PC_W-1:0] target,
    input  logic            flags_we,
    input  logic            alu_zero,
    input  logic            alu_cout,
    input  logic            err_clr,
    output logic [PC_W-1:0] pc,
    output logic            taken,
    output logic            zf,
    output logic            cf,
    output logic [LW-1:0]   stack_level,
    output logic            overflow,
    output logic            underflow,
    output logic            fault
);
    state_t          state, state_nx;
    logic            act, cond, ovf_ev, unf_ev, full, empty;
    logic [PC_W-1:0] pc_inc, pc_nx, top;

    return_stack #(.W(PC_W), .DEPTH(STACK_DEPTH), .LW(LW)) u_stack (
        .clk(clk), .rst(rst),
        .push(taken && jump_type == JT_JSB), .pop(taken && jump_type == JT_RET),
        .din(pc_inc), .top(top), .level(stack_level), .full(full), .empty(empty)
    );

    // branch resolution from registered flags and stack state, then next-PC mux
    always_comb begin
        act    = en && state == RUN;
        ovf_ev = act && jump_type == JT_JSB && full;
        unf_ev = act && jump_type == JT_RET && empty;
        cond   = jump_type == JT_JZ  ? zf :
                 jump_type == JT_JNZ ? !zf :
                 jump_type == JT_JC  ? cf :
                 jump_type == JT_JNC ? !cf :
                 jump_type == JT_JMP ? 1'b1 :
                 jump_type == JT_JSB ? !full :
                 jump_type == JT_RET ? !empty : 1'b0;
        taken  = act && cond;
        pc_inc = pc + 1'b1;
        pc_nx  = (!act || ovf_ev || unf_ev) ? pc :
                 !taken ? pc_inc :
                 jump_type == JT_RET ? top : target;
    end
    // FSM state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= RUN;
        else state <= state_nx;
    // FSM next state: trap on stack misuse, leave only on explicit clear
    always_comb
        state_nx = state == RUN ? ((ovf_ev || unf_ev) ? FAULT : RUN) : (err_clr ? RUN : FAULT);
    // FSM output
    always_comb
        fault = state == FAULT;
    // PC, flags and sticky fault causes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc        <= RESET_PC;
            zf        <= 1'b0;
            cf        <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pc <= pc_nx;
            if (act && flags_we) begin
                zf <= alu_zero;
                cf <= alu_cout;
            end
            if (ovf_ev) overflow <= 1'b1;
            if (unf_ev) underflow <= 1'b1;
            if (fault && err_clr) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
        end
endmodule
